// File: rtl/i2s_tx.sv
// Master-mode Philips I2S transmitter. BCLK and LRCLK are derived from clk.
// 16-bit stereo frames arrive through a one-entry valid/ready holding register.
module i2s_tx #(
  parameter int CLK_RATE   = 24576000,
  parameter int AUDIO_RATE = 48000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        frame_start,
  output logic        underrun,
  output logic [7:0]  underrun_count
);
  localparam int HALF  = CLK_RATE / (AUDIO_RATE * 64);
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;

  if (CLK_RATE % (AUDIO_RATE * 64) != 0) begin : g_bad_rate
    $error("i2s_tx: CLK_RATE must be an exact multiple of 64*AUDIO_RATE");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       slot;
  logic [4:0]       slot_inc;
  logic [31:0]      shifter;
  logic [31:0]      last;
  logic [15:0]      hold_l;
  logic [15:0]      hold_r;
  logic             hold_full;
  logic             div_wrap;
  logic             bclk_fall;
  logic             load;

  assign div_wrap     = (div_cnt == DIV_W'(HALF - 1));
  assign bclk_fall    = div_wrap & i2s_bclk;
  assign slot_inc     = slot + 5'd1;
  // A new frame enters the shifter one BCLK after LRCLK falls (Philips delay).
  assign load         = bclk_fall & (slot_inc == 5'd1);
  assign sample_ready = ~hold_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      i2s_bclk <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap) begin
        i2s_bclk <= ~i2s_bclk;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot      <= '0;
      shifter   <= '0;
      last      <= '0;
      i2s_sdata <= 1'b0;
      i2s_lrclk <= 1'b0;
    end else if (bclk_fall) begin
      slot      <= slot_inc;
      i2s_lrclk <= slot_inc[4];
      if (load) begin
        if (hold_full) begin
          shifter   <= {hold_l, hold_r};
          last      <= {hold_l, hold_r};
          i2s_sdata <= hold_l[15];
        end else begin
          shifter   <= last;
          i2s_sdata <= last[31];
        end
      end else begin
        shifter   <= {shifter[30:0], 1'b0};
        i2s_sdata <= shifter[30];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start    <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      frame_start <= load;
      underrun    <= load & ~hold_full;
      if (load && !hold_full && underrun_count != 8'hFF) begin
        underrun_count <= underrun_count + 8'd1;
      end
    end
  end

  // A load with the register full never meets a write, since ready is low then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else if (load && hold_full) begin
      hold_full <= 1'b0;
    end else if (sample_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_l    <= sample_l;
      hold_r    <= sample_r;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: three divider ratios share one stimulus stream; each has a
// frame-level reference model derived from edge arithmetic and the slot map.
module tb_i2s_tx;
  localparam int NCFG = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sl;
  logic [15:0] sr;
  logic        sv;
  logic        rdy   [NCFG];
  logic        bclk  [NCFG];
  logic        lrclk [NCFG];
  logic        sdata [NCFG];
  logic        fs    [NCFG];
  logic        ur    [NCFG];
  logic [7:0]  ucnt  [NCFG];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // LRCLK seen at the 32 BCLK rises of a frame: slots 1..31 then slot 0 of the next.
  function automatic logic [31:0] lr_expected();
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < 32; k++) begin
      v = {v[30:0], (((k + 1) % 32) >= 16) ? 1'b1 : 1'b0};
    end
    return v;
  endfunction

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int H = (gi == 0) ? 8 : (gi == 1) ? 4 : 1;
    int          m_edge = 0;
    int          m_cnt = 0;
    int          last_rise = -1;
    int          cap_k = 0;
    bit          m_full = 1'b0;
    bit          m_fs = 1'b0;
    bit          m_ur = 1'b0;
    bit          pre_ready;
    bit          prev_bclk = 1'b0;
    bit          cap_on = 1'b0;
    logic [31:0] m_hold = '0;
    logic [31:0] m_last = '0;
    logic [31:0] m_frame = '0;
    logic [31:0] cap_word = '0;
    logic [31:0] cap_lr = '0;
    logic [31:0] cap_exp = '0;
    string       pfx;

    i2s_tx #(.CLK_RATE(48000 * 64 * H), .AUDIO_RATE(48000)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .sample_l      (sl),
      .sample_r      (sr),
      .sample_valid  (sv),
      .sample_ready  (rdy[gi]),
      .i2s_bclk      (bclk[gi]),
      .i2s_lrclk     (lrclk[gi]),
      .i2s_sdata     (sdata[gi]),
      .frame_start   (fs[gi]),
      .underrun      (ur[gi]),
      .underrun_count(ucnt[gi])
    );

    // Inputs change at negedge+1, so here they still hold what the last posedge saw.
    always @(negedge clk) begin
      pfx = $sformatf("H%0d", H);
      if (reset) begin
        m_edge = 0; m_cnt = 0; m_full = 1'b0; m_fs = 1'b0; m_ur = 1'b0;
        m_hold = '0; m_last = '0; m_frame = '0;
        cap_on = 1'b0; prev_bclk = 1'b0; last_rise = -1;
        check({pfx, "_rst_bclk"},  32'(bclk[gi]),  32'd0);
        check({pfx, "_rst_lrclk"}, 32'(lrclk[gi]), 32'd0);
        check({pfx, "_rst_sdata"}, 32'(sdata[gi]), 32'd0);
        check({pfx, "_rst_fs"},    32'(fs[gi]),    32'd0);
        check({pfx, "_rst_ur"},    32'(ur[gi]),    32'd0);
        check({pfx, "_rst_ucnt"},  32'(ucnt[gi]),  32'd0);
        check({pfx, "_rst_ready"}, 32'(rdy[gi]),   32'd1);
      end else begin
        pre_ready = !m_full;
        m_edge++;
        m_fs = 1'b0;
        m_ur = 1'b0;
        if (m_edge >= 2 * H && (m_edge - 2 * H) % (64 * H) == 0) begin
          m_fs = 1'b1;
          if (m_full) begin
            m_frame = m_hold;
            m_full  = 1'b0;
          end else begin
            m_frame = m_last;
            m_ur    = 1'b1;
            if (m_cnt < 255) m_cnt++;
          end
          m_last = m_frame;
        end
        if (sv && pre_ready) begin
          m_hold = {sl, sr};
          m_full = 1'b1;
        end
        check({pfx, "_ready"},       32'(rdy[gi]),  32'(!m_full));
        check({pfx, "_frame_start"}, 32'(fs[gi]),   32'(m_fs));
        check({pfx, "_underrun"},    32'(ur[gi]),   32'(m_ur));
        check({pfx, "_ucount"},      32'(ucnt[gi]), 32'(m_cnt));
        if (m_fs) begin
          check({pfx, "_msb_at_load"}, 32'(sdata[gi]), 32'(m_frame[31]));
          cap_on  = 1'b1;
          cap_k   = 0;
          cap_exp = m_frame;
        end
        if (bclk[gi] && !prev_bclk) begin
          check({pfx, "_bclk_rise_gap"}, 32'((last_rise < 0) ? m_edge : m_edge - last_rise),
                32'((last_rise < 0) ? H : 2 * H));
          last_rise = m_edge;
          if (cap_on) begin
            cap_word = {cap_word[30:0], sdata[gi]};
            cap_lr   = {cap_lr[30:0], lrclk[gi]};
            cap_k++;
            if (cap_k == 32) begin
              check({pfx, "_frame_bits"}, cap_word, cap_exp);
              check({pfx, "_lrclk_map"},  cap_lr,   lr_expected());
              cap_on = 1'b0;
            end
          end
        end
        prev_bclk = bclk[gi];
      end
    end
  end

  // Holds valid until the H=8 instance accepts (ready at negedge+1 means accept next edge).
  task automatic send(input logic [15:0] l, input logic [15:0] r, input bit keep);
    bit done;
    done = 1'b0;
    sl = l;
    sr = r;
    sv = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      done = rdy[0];
      @(negedge clk);
      #1;
    end
    check("send_accepted", 32'(done), 32'd1);
    if (!keep) sv = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sl = '0;
    sr = '0;
    sv = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // Hold a sample, then reset mid-frame while BCLK is high.
    repeat (40) @(negedge clk);
    #1;
    send(16'($urandom), 16'($urandom), 1'b0);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 20 && !bclk[0]; i++) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_bclk",  32'(bclk[0]),  32'd0);
    check("midrst_lrclk", 32'(lrclk[0]), 32'd0);
    check("midrst_sdata", 32'(sdata[0]), 32'd0);
    check("midrst_ready", 32'(rdy[0]),   32'd1);
    check("midrst_ucnt",  32'(ucnt[0]),  32'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // Known pattern first, then three back-to-back random samples with valid held high.
    send(16'hA5F0, 16'h0F5A, 1'b0);
    for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 1'b1);
    sv = 1'b0;

    // Starve the transmitter so it repeats the last frame.
    repeat (4 * 512) @(negedge clk);
    #1;

    // Valid presented exactly on the H=8 load edge with the register empty.
    for (int i = 0; i < 1200 && ((g_cfg[0].m_edge + 1 - 16) % 512 != 0); i++) begin
      @(negedge clk);
      #1;
    end
    sl = 16'($urandom);
    sr = 16'($urandom);
    sv = 1'b1;
    @(negedge clk);
    #1;
    sv = 1'b0;
    repeat (3 * 512) @(negedge clk);

    // Long starvation drives the H=1 underrun counter into saturation.
    repeat (17000) @(negedge clk);
    #1;
    check("H1_ucount_saturated", 32'(ucnt[2]), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
